// File: rtl/multi_button_unit.sv
// ---------------------------------------------------------------------------
// multi_button_unit
//   N-channel push-button front end for the player control FSM. Each channel
//   runs a 2-FF synchronizer, a tick-sampled debouncer, one-clock press and
//   release pulses, long-press detection and (optionally) auto-repeat. A
//   single free-running divider generates the sample tick for all channels.
//
// Optional feature macro:
//   BTN_REPEAT_EN  when defined, a held button keeps emitting repeat pulses
//                  after its long press; when undefined the repeat logic is
//                  not built and repeat_o is tied low.
//
// Ports:
//   clk_i          system clock
//   reset_ni       asynchronous reset, active low
//   in_i           raw bouncy button inputs, 1 = pressed
//   level_o        debounced level per channel
//   press_o        1-clk pulse on debounced 0->1
//   release_o      1-clk pulse on debounced 1->0
//   long_press_o   1-clk pulse once per hold after LONG_TICKS ticks
//   repeat_o       1-clk auto-repeat pulses every REPEAT_TICKS ticks
// ---------------------------------------------------------------------------
module multi_button_unit #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 17,
  parameter int DB_SAMPLES   = 3,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [N_BTN-1:0] in_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_press_o,
  output logic [N_BTN-1:0] repeat_o
);

  localparam int HOLD_W = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
  localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
`endif

  // Elaboration-time sanity checks on the configuration.
  if (DB_SAMPLES < 2) begin : gBadDbSamples
    $error("multi_button_unit: DB_SAMPLES must be at least 2");
  end
  if (LONG_TICKS < 1) begin : gBadLongTicks
    $error("multi_button_unit: LONG_TICKS must be at least 1");
  end
  if (REPEAT_TICKS < 1) begin : gBadRepeatTicks
    $error("multi_button_unit: REPEAT_TICKS must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
`ifdef BTN_REPEAT_EN
    ,
    REPEAT
`endif
  } state_e;

  logic [TICK_DIV-1:0]                 tickCnt_q;
  logic                                tick;
  logic [N_BTN-1:0]                    sync1_q, sync2_q;
  logic [N_BTN-1:0][DB_SAMPLES-1:0]    samples_q, samples_d;
  logic [N_BTN-1:0]                    level_q, level_d;
  logic [N_BTN-1:0]                    levelDly_q;
  logic [N_BTN-1:0]                    press, rls;
  logic [N_BTN-1:0]                    longPulse, repeatPulse;
  state_e                              state_q [N_BTN];
  state_e                              state_d [N_BTN];
  logic [HOLD_W-1:0]                   holdCnt_q [N_BTN];
  logic [HOLD_W-1:0]                   holdCnt_d [N_BTN];
`ifdef BTN_REPEAT_EN
  logic [REP_W-1:0]                    repCnt_q [N_BTN];
  logic [REP_W-1:0]                    repCnt_d [N_BTN];
`endif

  // Shared sample tick: one clk wide when the divider reaches all-ones.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + TICK_DIV'(1);
    end
  end

  assign tick = &tickCnt_q;

  // Sample window shifts only on tick; level moves only on a unanimous window,
  // otherwise it holds, which is what rejects bounce.
  always_comb begin
    samples_d = samples_q;
    level_d   = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (tick) begin
        samples_d[i] = {samples_q[i][DB_SAMPLES-2:0], sync2_q[i]};
      end
      if (&samples_q[i]) begin
        level_d[i] = 1'b1;
      end else if (~|samples_q[i]) begin
        level_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      samples_q  <= '0;
      level_q    <= '0;
      levelDly_q <= '0;
    end else begin
      sync1_q    <= in_i;
      sync2_q    <= sync1_q;
      samples_q  <= samples_d;
      level_q    <= level_d;
      levelDly_q <= level_q;
    end
  end

  assign press = level_q & ~levelDly_q;
  assign rls   = ~level_q & levelDly_q;

  // Per-channel hold FSM. A low level forces IDLE on any clk and is tested
  // before the terminal count, so a release always suppresses long_press.
  always_comb begin
    longPulse   = '0;
    repeatPulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      holdCnt_d[i] = holdCnt_q[i];
`ifdef BTN_REPEAT_EN
      repCnt_d[i]  = repCnt_q[i];
`endif
      case (state_q[i])
        IDLE: begin
          if (press[i]) begin
            state_d[i]   = PRESSED;
            holdCnt_d[i] = '0;
          end
        end
        PRESSED: begin
          if (!level_q[i]) begin
            state_d[i] = IDLE;
          end else if (tick) begin
            if (holdCnt_q[i] == HOLD_LAST) begin
              state_d[i]   = HELD;
              longPulse[i] = 1'b1;
            end else begin
              holdCnt_d[i] = holdCnt_q[i] + HOLD_W'(1);
            end
          end
        end
        HELD: begin
          if (!level_q[i]) begin
            state_d[i] = IDLE;
`ifdef BTN_REPEAT_EN
          end else if (tick) begin
            state_d[i]  = REPEAT;
            repCnt_d[i] = '0;
`endif
          end
        end
`ifdef BTN_REPEAT_EN
        REPEAT: begin
          if (!level_q[i]) begin
            state_d[i] = IDLE;
          end else if (tick) begin
            if (repCnt_q[i] == REP_LAST) begin
              repeatPulse[i] = 1'b1;
              repCnt_d[i]    = '0;
            end else begin
              repCnt_d[i] = repCnt_q[i] + REP_W'(1);
            end
          end
        end
`endif
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= IDLE;
        holdCnt_q[i] <= '0;
`ifdef BTN_REPEAT_EN
        repCnt_q[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= state_d[i];
        holdCnt_q[i] <= holdCnt_d[i];
`ifdef BTN_REPEAT_EN
        repCnt_q[i]  <= repCnt_d[i];
`endif
      end
    end
  end

  assign level_o      = level_q;
  assign press_o      = press;
  assign release_o    = rls;
  assign long_press_o = longPulse;
`ifdef BTN_REPEAT_EN
  assign repeat_o     = repeatPulse;
`else
  assign repeat_o     = '0;
`endif

endmodule

// File: tb/tb_multi_button_unit.sv
// ---------------------------------------------------------------------------
// tb_multi_button_unit
//   Self-checking bench for multi_button_unit with a small configuration
//   (4 channels, tick every 4 clks, 3 debounce samples, long press after 5
//   ticks, repeat every 2 ticks). A behavioural model built from input
//   history, tick sample run lengths and "ticks since press" arithmetic
//   predicts every output on every clk; hand-derived pulse counts back up
//   the scripted segments.
// ---------------------------------------------------------------------------
module tb_multi_button_unit;

  localparam int N    = 4;
  localparam int TD   = 2;
  localparam int DB   = 3;
  localparam int LONG = 5;
  localparam int REP  = 2;
  localparam int P    = 1 << TD;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic [N-1:0] inVec = '1;
  logic [N-1:0] level, press, rel, longP, rep;

  int checks   = 0;
  int failures = 0;

  // Model state: cycle index since reset release and the input applied in
  // each cycle; debounce is tracked as the run length of equal tick samples.
  int           cyc;
  logic [N-1:0] hist[$];
  logic         mLevel [N];
  logic         mPrev [N];
  logic         pendLevel [N];
  logic         lastSample [N];
  int           runLen [N];
  int           pendAt;
  logic         mActive [N];
  int           mTicks [N];

  int nPress [N];
  int nRel [N];
  int nLong [N];
  int nRep [N];

  typedef struct {
    logic [N-1:0] inVal;
    int           cycles;
    logic [N-1:0] expPress;
    logic [N-1:0] expRel;
    logic [N-1:0] expLong;
  } seg_t;

  seg_t segs [8];

  always #5 clk = ~clk;

  multi_button_unit #(
    .N_BTN(N), .TICK_DIV(TD), .DB_SAMPLES(DB),
    .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
  ) dut (
    .clk_i(clk), .reset_ni(resetN), .in_i(inVec),
    .level_o(level), .press_o(press), .release_o(rel),
    .long_press_o(longP), .repeat_o(rep)
  );

  function automatic void modelReset();
    cyc    = 0;
    pendAt = -1;
    hist.delete();
    for (int i = 0; i < N; i++) begin
      mLevel[i]     = 1'b0;
      mPrev[i]      = 1'b0;
      pendLevel[i]  = 1'b0;
      lastSample[i] = 1'b0;
      runLen[i]     = DB;
      mActive[i]    = 1'b0;
      mTicks[i]     = 0;
    end
  endfunction

  function automatic void clearCounts();
    for (int i = 0; i < N; i++) begin
      nPress[i] = 0;
      nRel[i]   = 0;
      nLong[i]  = 0;
      nRep[i]   = 0;
    end
  endfunction

  // Advance the model across the clk edge that ends cycle cyc.
  function automatic void modelStep();
    logic         isTick;
    logic         s;
    logic [N-1:0] old;
    isTick = ((cyc % P) == P - 1);
    old    = (cyc >= 2) ? hist[cyc-2] : '0;
    for (int i = 0; i < N; i++) begin
      if (!mLevel[i]) begin
        mActive[i] = 1'b0;
      end else if (!mPrev[i]) begin
        mActive[i] = 1'b1;
        mTicks[i]  = 0;
      end else if (mActive[i] && isTick) begin
        mTicks[i]++;
      end
      mPrev[i] = mLevel[i];
      if (cyc == pendAt) mLevel[i] = pendLevel[i];
      if (isTick) begin
        s = old[i];
        if (s == lastSample[i]) begin
          runLen[i]++;
        end else begin
          runLen[i]     = 1;
          lastSample[i] = s;
        end
        if (runLen[i] >= DB) pendLevel[i] = s;
      end
    end
    if (isTick) pendAt = cyc + 1;
    cyc++;
  endfunction

  task automatic checkOutput();
    logic [N-1:0] eL, eP, eR, eLg, eRp;
    logic         isTick;
    int           k;
    isTick = ((cyc % P) == P - 1);
    for (int i = 0; i < N; i++) begin
      k      = mTicks[i] + 1;
      eL[i]  = mLevel[i];
      eP[i]  = mLevel[i] & ~mPrev[i];
      eR[i]  = ~mLevel[i] & mPrev[i];
      eLg[i] = isTick && mActive[i] && mLevel[i] && (k == LONG);
      eRp[i] = 1'b0;
`ifdef BTN_REPEAT_EN
      eRp[i] = isTick && mActive[i] && mLevel[i] && (k > LONG + 1) && (((k - LONG - 1) % REP) == 0);
`endif
    end
    checks++;
    if ({level, press, rel, longP, rep} !== {eL, eP, eR, eLg, eRp}) begin
      failures++;
      $display("[TB] FAIL cycle%0d got lvl=%b prs=%b rel=%b lng=%b rep=%b want lvl=%b prs=%b rel=%b lng=%b rep=%b",
               cyc, level, press, rel, longP, rep, eL, eP, eR, eLg, eRp);
    end
    for (int i = 0; i < N; i++) begin
      if (press[i]) nPress[i]++;
      if (rel[i])   nRel[i]++;
      if (longP[i]) nLong[i]++;
      if (rep[i])   nRep[i]++;
    end
  endtask

  // Called at a negedge: check this cycle, drive the next input, cross the edge.
  task automatic applyStimulus(input logic [N-1:0] v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      checkOutput();
      inVec = v;
      hist.push_back(v);
      @(posedge clk);
      modelStep();
      @(negedge clk);
    end
  endtask

  task automatic checkZero(input string name);
    checks++;
    if ({level, press, rel, longP, rep} !== '0) begin
      failures++;
      $display("[TB] FAIL %s got lvl=%b prs=%b rel=%b lng=%b rep=%b want all 0",
               name, level, press, rel, longP, rep);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic doReset(input logic [N-1:0] vDuring, input logic [N-1:0] vAfter);
    inVec  = vDuring;
    resetN = 1'b0;
    #1;
    checkZero("reset_immediate");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkZero("reset_hold");
    end
    modelReset();
    clearCounts();
    inVec  = vAfter;
    resetN = 1'b1;
  endtask

  // Main sequence: scripted segments, multi-cycle corner cases, then random.
  initial begin
    logic [N-1:0] v;
    int           holdLeft [N];
    int           expRep;

    segs[0] = '{4'b0000, 20, 4'b0000, 4'b0000, 4'b0000};
    segs[1] = '{4'b0001, 16, 4'b0001, 4'b0000, 4'b0000};
    segs[2] = '{4'b0001, 30, 4'b0000, 4'b0000, 4'b0001};
    segs[3] = '{4'b0000, 20, 4'b0000, 4'b0001, 4'b0000};
    segs[4] = '{4'b1000, 14, 4'b0000, 4'b0000, 4'b0000};
    segs[5] = '{4'b0000, 30, 4'b1000, 4'b1000, 4'b0000};
    segs[6] = '{4'b0110, 40, 4'b0110, 4'b0000, 4'b0110};
    segs[7] = '{4'b0000, 20, 4'b0000, 4'b0110, 4'b0000};

    modelReset();
    clearCounts();
    @(negedge clk);
    doReset('1, '0);

    for (int s = 0; s < 8; s++) begin
      clearCounts();
      applyStimulus(segs[s].inVal, segs[s].cycles);
      for (int i = 0; i < N; i++) begin
        checkCount($sformatf("seg%0d_press%0d", s, i), nPress[i], segs[s].expPress[i] ? 1 : 0);
        checkCount($sformatf("seg%0d_release%0d", s, i), nRel[i], segs[s].expRel[i] ? 1 : 0);
        checkCount($sformatf("seg%0d_long%0d", s, i), nLong[i], segs[s].expLong[i] ? 1 : 0);
      end
    end

    // Bouncing channel 1: toggling every 3 clks never gives 3 agreeing samples.
    doReset('0, '0);
    for (int j = 0; j < 40; j++) begin
      applyStimulus((((j / 3) % 2) == 1) ? 4'b0010 : 4'b0000, 1);
    end
    applyStimulus(4'b0010, 60);
    checkCount("bounce_press1", nPress[1], 1);
    checkCount("bounce_release1", nRel[1], 0);

    // Channel 2 held for 30 ticks, then released.
    doReset('0, '0);
    applyStimulus(4'b0100, 120);
    applyStimulus(4'b0000, 20);
`ifdef BTN_REPEAT_EN
    expRep = 12;
`else
    expRep = 0;
`endif
    checkCount("hold_press2", nPress[2], 1);
    checkCount("hold_long2", nLong[2], 1);
    checkCount("hold_repeat2", nRep[2], expRep);
    checkCount("hold_release2", nRel[2], 1);

    // Reset in the middle of an all-channel hold: no release pulses follow.
    doReset('0, '0);
    applyStimulus(4'b1111, 40);
    doReset(4'b1111, '0);
    applyStimulus(4'b0000, 30);
    for (int i = 0; i < N; i++) begin
      checkCount($sformatf("midreset_release%0d", i), nRel[i], 0);
    end

    // Random hold lengths mix short bounces with long holds.
    doReset('0, '0);
    v = '0;
    for (int i = 0; i < N; i++) holdLeft[i] = $urandom_range(1, 60);
    for (int j = 0; j < 3000; j++) begin
      if (j == 1500) doReset(v, v);
      for (int i = 0; i < N; i++) begin
        holdLeft[i]--;
        if (holdLeft[i] <= 0) begin
          v[i]        = ~v[i];
          holdLeft[i] = $urandom_range(1, 60);
        end
      end
      applyStimulus(v, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
